// File: rtl/display_shift_driver.sv
// display_shift_driver
// Walks the six display digits (hours MSD first), fetches each digit's
// segment pattern from an external BCD segment mux, and shifts
// {dp, segments} MSB first into an external shift register. A storage
// latch pulse follows the last bit. Every output is a registered copy of
// the FSM's view, so the board sees clean, glitch-free edges.
module display_shift_driver #(
  parameter int HALF_PERIOD = 1,
  parameter int NUM_DIGITS  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       start,
  input  logic [6:0] led_in,
  input  logic [5:0] dp_mask,
  output logic [2:0] segment_select,
  output logic       serial_data,
  output logic       serial_clk,
  output logic       serial_latch,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  // Last value of the phase counter before a timed state is left.
  localparam logic [7:0] PHASE_LAST  = 8'(HALF_PERIOD - 1);
  // Digit index that opens every frame.
  localparam logic [2:0] FIRST_DIGIT = 3'(NUM_DIGITS - 1);
  // Segment-select code that makes the mux blank its output.
  localparam logic [2:0] SEL_BLANK   = 3'h7;

  state_t     state;
  logic [7:0] phase;
  logic [2:0] digit;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [7:0] dp_ext;
  logic       phase_end;

  // Widened so every 3-bit digit index addresses a real bit.
  assign dp_ext    = {2'b00, dp_mask};
  assign phase_end = (phase == PHASE_LAST);

  // Frame sequencer: outputs are set on the edge that enters each state so
  // they always describe the state currently held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      phase          <= 8'd0;
      digit          <= 3'd0;
      bit_cnt        <= 3'd0;
      shift_reg      <= 8'd0;
      segment_select <= SEL_BLANK;
      serial_data    <= 1'b0;
      serial_clk     <= 1'b0;
      serial_latch   <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && en) begin
            state          <= SELECT;
            phase          <= 8'd0;
            digit          <= FIRST_DIGIT;
            segment_select <= FIRST_DIGIT;
            busy           <= 1'b1;
          end
        end

        SELECT: begin
          state <= LOAD;
          phase <= 8'd0;
        end

        LOAD: begin
          shift_reg   <= {dp_ext[digit], led_in};
          bit_cnt     <= 3'd7;
          serial_data <= dp_ext[digit];
          serial_clk  <= 1'b0;
          state       <= SHIFT_LO;
          phase       <= 8'd0;
        end

        SHIFT_LO: begin
          if (phase_end) begin
            state      <= SHIFT_HI;
            serial_clk <= 1'b1;
            phase      <= 8'd0;
          end else begin
            phase <= phase + 8'd1;
          end
        end

        SHIFT_HI: begin
          if (phase_end) begin
            phase      <= 8'd0;
            shift_reg  <= {shift_reg[6:0], 1'b0};
            serial_clk <= 1'b0;
            if (bit_cnt != 3'd0) begin
              bit_cnt     <= bit_cnt - 3'd1;
              serial_data <= shift_reg[6];
              state       <= SHIFT_LO;
            end else if (digit != 3'd0) begin
              digit          <= digit - 3'd1;
              segment_select <= digit - 3'd1;
              state          <= SELECT;
            end else begin
              serial_latch <= 1'b1;
              serial_data  <= 1'b0;
              state        <= LATCH;
            end
          end else begin
            phase <= phase + 8'd1;
          end
        end

        LATCH: begin
          if (phase_end) begin
            state          <= IDLE;
            phase          <= 8'd0;
            serial_latch   <= 1'b0;
            segment_select <= SEL_BLANK;
            busy           <= 1'b0;
            frame_done     <= 1'b1;
          end else begin
            phase <= phase + 8'd1;
          end
        end

        default: begin
          state          <= IDLE;
          phase          <= 8'd0;
          segment_select <= SEL_BLANK;
          serial_data    <= 1'b0;
          serial_clk     <= 1'b0;
          serial_latch   <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_shift_driver.sv
// tb_display_shift_driver
// Two drivers share clock and reset: dut_a with HALF_PERIOD=1 and dut_b
// with HALF_PERIOD=3. Each sees a model segment mux. Expected bytes are
// queued when a frame is requested and popped as bytes are reassembled
// from serial_clk rising edges.
module tb_display_shift_driver;

  logic       clk;
  logic       reset;

  logic       a_en, a_start, a_sdata, a_sclk, a_latch, a_busy, a_done;
  logic [6:0] a_led;
  logic [5:0] a_dp;
  logic [2:0] a_sel;
  logic       b_en, b_start, b_sdata, b_sclk, b_latch, b_busy, b_done;
  logic [6:0] b_led;
  logic [5:0] b_dp;
  logic [2:0] b_sel;
  bit         uni_a;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] a_q[$];
  logic [7:0] b_q[$];

  // monitor state and statistics
  int a_rises, a_latch_cyc, a_done_cnt, a_frames, a_busy_len, a_gap;
  int a_busy_run, a_idle_run, a_bitn;
  logic [7:0] a_byte;
  logic a_prev_sclk, a_prev_sdata, a_prev_busy;
  int b_rises, b_done_cnt, b_busy_len, b_busy_run, b_bitn, b_hi_run, b_lo_run;
  logic [7:0] b_byte;
  logic b_prev_sclk, b_prev_sdata, b_prev_busy;

  display_shift_driver #(.HALF_PERIOD(1), .NUM_DIGITS(6)) dut_a (
    .clk(clk), .reset(reset), .en(a_en), .start(a_start), .led_in(a_led),
    .dp_mask(a_dp), .segment_select(a_sel), .serial_data(a_sdata),
    .serial_clk(a_sclk), .serial_latch(a_latch), .busy(a_busy),
    .frame_done(a_done)
  );

  display_shift_driver #(.HALF_PERIOD(3), .NUM_DIGITS(6)) dut_b (
    .clk(clk), .reset(reset), .en(b_en), .start(b_start), .led_in(b_led),
    .dp_mask(b_dp), .segment_select(b_sel), .serial_data(b_sdata),
    .serial_clk(b_sclk), .serial_latch(b_latch), .busy(b_busy),
    .frame_done(b_done)
  );

  always #5 clk = ~clk;

  // model BCD segment mux: distinct pattern per digit, blank otherwise
  function automatic logic [6:0] pat(input logic [2:0] sel);
    case (sel)
      3'd0:    return 7'h3F;
      3'd1:    return 7'h06;
      3'd2:    return 7'h5B;
      3'd3:    return 7'h4F;
      3'd4:    return 7'h66;
      3'd5:    return 7'h6D;
      default: return 7'h00;
    endcase
  endfunction

  assign a_led = uni_a ? 7'h7E : pat(a_sel);
  assign b_led = pat(b_sel);

  function automatic logic [7:0] expByte(input int d, input logic [5:0] dp, input bit uni);
    logic [6:0] seg;
    seg = uni ? 7'h7E : pat(3'(d));
    return {dp[d], seg};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearStats();
    a_rises = 0; a_latch_cyc = 0; a_done_cnt = 0; a_frames = 0;
    b_rises = 0; b_done_cnt = 0;
  endtask

  task automatic pushFrame(input bit which);
    for (int d = 5; d >= 0; d--) begin
      if (which) b_q.push_back(expByte(d, b_dp, 1'b0));
      else       a_q.push_back(expByte(d, a_dp, uni_a));
    end
  endtask

  task automatic pulseStart(input bit which);
    @(posedge clk); #1;
    if (which) b_start = 1'b1; else a_start = 1'b1;
    @(posedge clk); #1;
    if (which) b_start = 1'b0; else a_start = 1'b0;
  endtask

  task automatic applyStimulus(input bit which);
    pushFrame(which);
    pulseStart(which);
  endtask

  task automatic waitDone(input bit which, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk); #1;
      seen = which ? b_done : a_done;
    end
    checkOutput(which ? "b_frame_done_seen" : "a_frame_done_seen", 32'(seen), 1);
  endtask

  // dut_a monitor: byte reassembly, hold check, busy/idle run lengths
  always @(negedge clk) begin
    if (reset) begin
      a_bitn = 0;
      a_byte = 8'd0;
    end else begin
      if (a_sclk && a_prev_sclk)
        checkOutput("a_data_stable_high", 32'(a_sdata), 32'(a_prev_sdata));
      if (a_sclk && !a_prev_sclk) begin
        a_rises++;
        a_byte = {a_byte[6:0], a_sdata};
        a_bitn++;
        if (a_bitn == 8) begin
          a_bitn = 0;
          checkOutput("a_byte_expected", 32'(a_q.size() != 0), 1);
          if (a_q.size() != 0) checkOutput("a_byte", a_byte, a_q.pop_front());
        end
      end
    end
    if (a_busy && !a_prev_busy) begin
      a_frames++;
      a_gap = a_idle_run;
      a_busy_run = 0;
    end
    if (!a_busy && a_prev_busy) begin
      a_busy_len = a_busy_run;
      a_idle_run = 0;
    end
    if (a_busy) a_busy_run++; else a_idle_run++;
    if (a_latch) a_latch_cyc++;
    if (a_done) a_done_cnt++;
    a_prev_sclk  = a_sclk;
    a_prev_sdata = a_sdata;
    a_prev_busy  = a_busy;
  end

  // dut_b monitor: byte reassembly and serial_clk phase lengths
  always @(negedge clk) begin
    if (reset) begin
      b_bitn = 0;
      b_byte = 8'd0;
      b_hi_run = 0;
      b_lo_run = 0;
    end else begin
      if (b_sclk && b_prev_sclk)
        checkOutput("b_data_stable_high", 32'(b_sdata), 32'(b_prev_sdata));
      if (!b_sclk && b_prev_sclk)
        checkOutput("b_high_phase_len", b_hi_run, 3);
      if (b_sclk && !b_prev_sclk) begin
        if (b_bitn != 0) checkOutput("b_low_phase_len", b_lo_run, 3);
        b_rises++;
        b_byte = {b_byte[6:0], b_sdata};
        b_bitn++;
        if (b_bitn == 8) begin
          b_bitn = 0;
          checkOutput("b_byte_expected", 32'(b_q.size() != 0), 1);
          if (b_q.size() != 0) checkOutput("b_byte", b_byte, b_q.pop_front());
        end
      end
      if (b_sclk) begin b_hi_run++; b_lo_run = 0; end
      else        begin b_lo_run++; b_hi_run = 0; end
    end
    if (b_busy && !b_prev_busy) b_busy_run = 0;
    if (!b_busy && b_prev_busy) b_busy_len = b_busy_run;
    if (b_busy) b_busy_run++;
    if (b_done) b_done_cnt++;
    b_prev_sclk  = b_sclk;
    b_prev_sdata = b_sdata;
    b_prev_busy  = b_busy;
  end

  // watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    clk = 1'b0; reset = 1'b1; uni_a = 1'b1;
    a_en = 1'b1; a_start = 1'b0; a_dp = 6'd0;
    b_en = 1'b1; b_start = 1'b0; b_dp = 6'd0;
    a_prev_sclk = 0; a_prev_sdata = 0; a_prev_busy = 0;
    b_prev_sclk = 0; b_prev_sdata = 0; b_prev_busy = 0;
    a_busy_run = 0; a_idle_run = 0; a_busy_len = 0; a_gap = 0; a_bitn = 0; a_byte = 0;
    b_busy_run = 0; b_busy_len = 0; b_bitn = 0; b_byte = 0; b_hi_run = 0; b_lo_run = 0;
    clearStats();

    // reset state: {sel, data, clk, latch, busy, done}
    repeat (3) @(posedge clk); #1;
    checkOutput("a_reset_state", {24'd0, a_sel, a_sdata, a_sclk, a_latch, a_busy, a_done}, 32'hE0);
    checkOutput("b_reset_state", {24'd0, b_sel, b_sdata, b_sclk, b_latch, b_busy, b_done}, 32'hE0);
    reset = 1'b0;
    $display("[TB] uniform 7E frame, HALF_PERIOD=1");

    clearStats();
    applyStimulus(0);
    waitDone(0, 200);
    checkOutput("a_busy_len_h1", a_busy_len, 109);
    checkOutput("a_rises_h1", a_rises, 48);
    checkOutput("a_latch_cycles", a_latch_cyc, 1);
    checkOutput("a_done_pulses", a_done_cnt, 1);
    checkOutput("a_bytes_left", a_q.size(), 0);
    @(negedge clk); #1;
    checkOutput("a_done_one_cycle", 32'(a_done), 0);
    checkOutput("a_idle_sel", 32'(a_sel), 7);

    $display("[TB] per-digit patterns with decimal points");
    uni_a = 1'b0;
    a_dp  = 6'b010100;
    clearStats();
    applyStimulus(0);
    checkOutput("a_first_sel", 32'(a_sel), 5);
    checkOutput("a_busy_after_start", 32'(a_busy), 1);
    waitDone(0, 200);
    checkOutput("a_bytes_left_dp", a_q.size(), 0);
    checkOutput("a_rises_dp", a_rises, 48);
    checkOutput("a_idle_sel_after", 32'(a_sel), 7);
    checkOutput("a_idle_latch", 32'(a_latch), 0);

    $display("[TB] starts while busy, en dropped mid-frame");
    a_dp = 6'd0;
    clearStats();
    applyStimulus(0);
    repeat (8) @(posedge clk);
    pulseStart(0);
    repeat (38) @(posedge clk);
    pulseStart(0);
    repeat (10) @(posedge clk);
    #1 a_en = 1'b0;
    waitDone(0, 200);
    checkOutput("a_busy_len_en_drop", a_busy_len, 109);
    checkOutput("a_bytes_left_en_drop", a_q.size(), 0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("a_no_queued_frame", a_frames, 1);
    checkOutput("a_idle_after_ignored", 32'(a_busy), 0);
    pulseStart(0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("a_en_low_blocks", 32'(a_busy), 0);
    checkOutput("a_frames_en_low", a_frames, 1);
    a_en = 1'b1;

    $display("[TB] reset mid-frame at digit 2 bit 3");
    clearStats();
    applyStimulus(0);
    guard = 0;
    while (a_rises < 27 && guard < 300) begin
      @(negedge clk); #1;
      guard++;
    end
    checkOutput("a_reached_digit2_bit3", a_rises, 27);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("a_abort_state", {24'd0, a_sel, a_sdata, a_sclk, a_latch, a_busy, a_done}, 32'hE0);
    reset = 1'b0;
    a_q.delete();
    repeat (5) @(negedge clk);
    #1;
    checkOutput("a_abort_no_latch", a_latch_cyc, 0);
    checkOutput("a_abort_no_done", a_done_cnt, 0);
    checkOutput("a_abort_idle", 32'(a_busy), 0);
    clearStats();
    applyStimulus(0);
    waitDone(0, 200);
    checkOutput("a_clean_busy_len", a_busy_len, 109);
    checkOutput("a_clean_rises", a_rises, 48);
    checkOutput("a_clean_latch", a_latch_cyc, 1);
    checkOutput("a_clean_bytes_left", a_q.size(), 0);

    $display("[TB] start held high, back-to-back frames");
    clearStats();
    pushFrame(0);
    pushFrame(0);
    @(posedge clk); #1;
    a_start = 1'b1;
    waitDone(0, 200);
    checkOutput("a_done_cycle_idle", 32'(a_busy), 0);
    @(posedge clk); #1;
    a_start = 1'b0;
    checkOutput("a_restart_busy", 32'(a_busy), 1);
    checkOutput("a_restart_done_low", 32'(a_done), 0);
    waitDone(0, 200);
    checkOutput("a_gap_cycles", a_gap, 1);
    checkOutput("a_b2b_frames", a_frames, 2);
    checkOutput("a_b2b_bytes_left", a_q.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("a_b2b_idle_after", 32'(a_busy), 0);

    $display("[TB] HALF_PERIOD=3 frame");
    b_dp = 6'b100001;
    clearStats();
    applyStimulus(1);
    waitDone(1, 400);
    checkOutput("b_busy_len_h3", b_busy_len, 303);
    checkOutput("b_rises_h3", b_rises, 48);
    checkOutput("b_done_pulses", b_done_cnt, 1);
    checkOutput("b_bytes_left", b_q.size(), 0);
    checkOutput("b_idle_sel", 32'(b_sel), 7);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
